serializer: RTL and testbench



---
 rtl/serializer_pkg.sv | 14 +
 rtl/piso_shift_reg.sv | 42 ++++
 rtl/serializer.sv | 149 ++++++++++++++
 tb/tb_serializer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types and defaults for the bit-serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serializer_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_GAP
  } tx_state_t;

  localparam int TX_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register; hides bit order from the FSM.
// Latency: q_bit shows the next bit to send as soon as load/shift takes effect.
// Backpressure: none here; the caller gates shift_en with the receiver's ready.
//
// Ports:
//   clk, reset_n  link clock, synchronous active-low reset
//   load          copy d into the register (wins over shift_en)
//   shift_en      advance to the next bit
//   d             word to serialise
//   q_bit         bit that will be driven on the next send
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             q_bit
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift_en) begin
      // Vacated positions fill with zero; they are never sent.
      if (MSB_FIRST) begin
        sr <= {sr[WIDTH-2:0], 1'b0};
      end else begin
        sr <= {1'b0, sr[WIDTH-1:1]};
      end
    end
  end

  assign q_bit = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial transmitter with a one-entry holding buffer.
// Latency: capture at edge N, load at N+1, first serial bit after edge N+2.
// Backpressure: rx_ready = 0 freezes the bit stream; status_out = 0 while buffer full.
//
// Ports:
//   clk_100khz, reset_n   link clock, synchronous active-low reset
//   byte_in/byte_valid    producer word and level valid
//   byte_ack              one-cycle pulse when a word is captured
//   status_out            1 = holding buffer empty
//   rx_ready              receiver may accept a bit this edge
//   data_out/write_out    serial bit and its qualifier
//   tx_done               one-cycle pulse after the last bit of a word
module serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH      = TX_WIDTH_DEFAULT,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk_100khz,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] byte_in,
  input  logic             byte_valid,
  output logic             byte_ack,
  output logic             status_out,
  input  logic             rx_ready,
  output logic             data_out,
  output logic             write_out,
  output logic             tx_done
);

  localparam int CW       = $clog2(WIDTH + 1);
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  tx_state_t        state;
  logic [WIDTH-1:0] hold_buf;
  logic             buf_full;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             done_pend;

  logic             capture;
  logic             send_bit;
  logic             last_bit;
  logic             sr_load;
  logic             sr_bit;

  always_comb begin
    // The ack cycle blocks capture so a level-held byte_valid is not taken twice.
    capture  = byte_valid && !buf_full && !byte_ack;
    send_bit = (state == TX_SHIFT) && rx_ready;
    last_bit = send_bit && (bit_cnt == CW'(WIDTH - 1));
    // Back-to-back reload happens on the edge that sends the last bit, so the
    // next word's first bit follows with no bubble.
    sr_load  = ((state == TX_IDLE) && buf_full) ||
               (last_bit && (GAP_CYCLES == 0) && buf_full);
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk      (clk_100khz),
    .reset_n  (reset_n),
    .load     (sr_load),
    .shift_en (send_bit),
    .d        (hold_buf),
    .q_bit    (sr_bit)
  );

  always_ff @(posedge clk_100khz) begin
    if (!reset_n) begin
      state     <= TX_IDLE;
      hold_buf  <= '0;
      buf_full  <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      done_pend <= 1'b0;
      byte_ack  <= 1'b0;
      data_out  <= 1'b0;
      write_out <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      byte_ack  <= capture;
      tx_done   <= done_pend;
      done_pend <= 1'b0;

      if (capture) begin
        hold_buf <= byte_in;
      end
      // capture needs an empty buffer and sr_load a full one, so they never collide.
      if (sr_load) begin
        buf_full <= 1'b0;
      end else if (capture) begin
        buf_full <= 1'b1;
      end

      case (state)
        TX_IDLE: begin
          write_out <= 1'b0;
          if (buf_full) begin
            state   <= TX_SHIFT;
            bit_cnt <= '0;
          end
        end

        TX_SHIFT: begin
          if (rx_ready) begin
            data_out  <= sr_bit;
            write_out <= 1'b1;
            if (last_bit) begin
              bit_cnt   <= '0;
              done_pend <= 1'b1;
              if (GAP_CYCLES > 0) begin
                state   <= TX_GAP;
                gap_cnt <= '0;
              end else if (!buf_full) begin
                state <= TX_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else begin
            // data_out keeps its last value while stalled.
            write_out <= 1'b0;
          end
        end

        TX_GAP: begin
          write_out <= 1'b0;
          if (gap_cnt == GW'(GAP_LAST)) begin
            state <= TX_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: begin
          state     <= TX_IDLE;
          write_out <= 1'b0;
        end
      endcase
    end
  end

  assign status_out = ~buf_full;

endmodule

// File: tb/tb_serializer.sv
// Directed plus randomized bench for the serializer with a word-level reference model.
// Latency: n/a (testbench).
// Backpressure: rx_ready is driven directly or randomly by the bench.
module tb_serializer;

  logic       clk_100khz = 1'b0;
  logic       reset_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ack;
  logic       status_out;
  logic       rx_ready;
  logic       data_out;
  logic       write_out;
  logic       tx_done;

  serializer #(
    .WIDTH      (8),
    .MSB_FIRST  (1'b1),
    .GAP_CYCLES (0)
  ) dut (
    .clk_100khz (clk_100khz),
    .reset_n    (reset_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ack   (byte_ack),
    .status_out (status_out),
    .rx_ready   (rx_ready),
    .data_out   (data_out),
    .write_out  (write_out),
    .tx_done    (tx_done)
  );

  always #5 clk_100khz = ~clk_100khz;

  int errors = 0;
  int checks = 0;

  // Receiver-side observation: serial bits, tx_done pulses, write_out runs.
  logic       rx_bits[$];
  logic [7:0] exp_q[$];
  int         cyc      = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         run      = 0;
  int         max_run  = 0;
  bit         rand_rdy = 1'b0;
  logic       ack_wo;
  int         ack_cyc;

  always @(posedge clk_100khz) begin
    #1;
    cyc = cyc + 1;
    if (write_out === 1'b1) begin
      rx_bits.push_back(data_out);
      run = run + 1;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (tx_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; in random mode the receiver is busy about 1 cycle in 4.
  task automatic tick();
    @(negedge clk_100khz);
    if (rand_rdy) rx_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Offer a word and hold byte_valid until the ack pulse is seen.
  task automatic offer(input logic [7:0] w);
    logic got;
    got        = 1'b0;
    byte_in    = w;
    byte_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (byte_ack === 1'b1) got = 1'b1;
    end
    ack_wo     = write_out;
    ack_cyc    = cyc;
    byte_valid = 1'b0;
    exp_q.push_back(w);
    chk("ack_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_done(input int target);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (done_cnt >= target) ok = 1'b1;
      else tick();
    end
    chk("done_timeout", {31'd0, ok}, 32'd1);
  endtask

  // Reference model: the stream regrouped into 8-bit words, first bit = MSB.
  task automatic check_stream(input string tag);
    logic [7:0] w;
    chk({tag, "_bits"}, rx_bits.size(), exp_q.size() * 8);
    for (int k = 0; k < exp_q.size() && (k * 8 + 7) < rx_bits.size(); k++) begin
      w = '0;
      for (int j = 0; j < 8; j++) w = {w[6:0], rx_bits[k * 8 + j]};
      chk({tag, "_word"}, {24'd0, w}, {24'd0, exp_q[k]});
    end
  endtask

  task automatic clear_model();
    rx_bits.delete();
    exp_q.delete();
    max_run = 0;
  endtask

  initial begin
    logic [7:0] w;
    int         d0;
    logic       ok;

    // 1: reset held with byte_valid asserted
    reset_n    = 1'b0;
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    rx_ready   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ack", {31'd0, byte_ack}, 32'd0);
      chk("rst_status", {31'd0, status_out}, 32'd1);
      chk("rst_wr", {31'd0, write_out}, 32'd0);
      chk("rst_data", {31'd0, data_out}, 32'd0);
      chk("rst_done", {31'd0, tx_done}, 32'd0);
    end
    byte_valid = 1'b0;
    reset_n    = 1'b1;
    tick();
    clear_model();

    // 2: single word, exact cycle timing
    w          = 8'hA5;
    d0         = done_cnt;
    byte_in    = w;
    byte_valid = 1'b1;
    tick();
    chk("t2_ack", {31'd0, byte_ack}, 32'd1);
    chk("t2_status_full", {31'd0, status_out}, 32'd0);
    byte_valid = 1'b0;
    tick();
    chk("t2_ack_once", {31'd0, byte_ack}, 32'd0);
    chk("t2_status_load", {31'd0, status_out}, 32'd1);
    chk("t2_wr_load", {31'd0, write_out}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_wr", {31'd0, write_out}, 32'd1);
      chk("t2_bit", {31'd0, data_out}, {31'd0, w[7 - i]});
      chk("t2_no_done", {31'd0, tx_done}, 32'd0);
    end
    tick();
    chk("t2_wr_end", {31'd0, write_out}, 32'd0);
    chk("t2_done", {31'd0, tx_done}, 32'd1);
    tick();
    chk("t2_done_pulse", {31'd0, tx_done}, 32'd0);
    chk("t2_done_cnt", done_cnt - d0, 32'd1);
    exp_q.push_back(w);
    check_stream("t2");
    clear_model();

    // 3: back-to-back words
    d0 = done_cnt;
    offer(8'h3C);
    offer(8'hC3);
    chk("t3_ack_while_shift", {31'd0, ack_wo}, 32'd1);
    wait_done(d0 + 2);
    repeat (3) tick();
    chk("t3_run", max_run, 32'd16);
    check_stream("t3");
    clear_model();

    // 4: three-cycle stall mid-word
    d0 = done_cnt;
    offer(8'hF0);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (rx_bits.size() >= 3) ok = 1'b1;
      else tick();
    end
    chk("t4_reach_bit3", {31'd0, ok}, 32'd1);
    rx_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("t4_stall_wr", {31'd0, write_out}, 32'd0);
    end
    rx_ready = 1'b1;
    wait_done(d0 + 1);
    chk("t4_done_delay", done_cyc - ack_cyc, 32'd13);
    check_stream("t4");
    clear_model();

    // 5: reset after four bits
    offer(8'hFF);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (rx_bits.size() >= 4) ok = 1'b1;
      else tick();
    end
    chk("t5_reach_bit4", {31'd0, ok}, 32'd1);
    d0      = done_cnt;
    reset_n = 1'b0;
    tick();
    chk("t5_wr_reset", {31'd0, write_out}, 32'd0);
    chk("t5_status_reset", {31'd0, status_out}, 32'd1);
    tick();
    reset_n = 1'b1;
    clear_model();
    repeat (12) tick();
    chk("t5_no_done", done_cnt - d0, 32'd0);
    chk("t5_no_bits", rx_bits.size(), 32'd0);
    offer(8'h81);
    wait_done(d0 + 1);
    check_stream("t5");
    clear_model();

    // 6: eight random words against a randomly busy receiver
    d0       = done_cnt;
    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++) offer(8'($urandom));
    wait_done(d0 + 8);
    rand_rdy = 1'b0;
    rx_ready = 1'b1;
    repeat (3) tick();
    chk("t6_done_cnt", done_cnt - d0, 32'd8);
    check_stream("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
